// File: rtl/gate_pkg.sv
// Shared definitions for the gate_scan register block: register offsets,
// CTRL/ERR bit positions and the scan engine state encoding.
package gate_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_ERR      = 3'd1;
  localparam logic [2:0] REG_GATE     = 3'd2;
  localparam logic [2:0] REG_MASK_LO  = 3'd3;
  localparam logic [2:0] REG_MASK_HI  = 3'd4;
  localparam logic [2:0] REG_DWELL_LO = 3'd5;
  localparam logic [2:0] REG_DWELL_HI = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam int CTRL_SRST     = 0;
  localparam int CTRL_SCAN_EN  = 1;
  localparam int CTRL_ONE_SHOT = 2;

  localparam int ERR_RANGE  = 0;
  localparam int ERR_LOCKED = 1;
  localparam int ERR_EMPTY  = 2;
  localparam int ERR_BUSY   = 3;
  localparam int ERR_BITS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_DWELL = 2'd2
  } scan_state_e;

endpackage

// File: rtl/gate_led_dec.sv
// Registered one-hot decoder from gate number to LED bank; bit i lights for
// gate i+1, gate 0 lights nothing.
module gate_led_dec
  import gate_pkg::*;
#(
  parameter int N_GATES   = 10,
  parameter int OUT_WIDTH = $clog2(N_GATES + 1)
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 clr,
  input  logic [OUT_WIDTH-1:0] gate,
  output logic [N_GATES-1:0]   leds
);

  logic [N_GATES-1:0] onehot_s;
  logic [N_GATES-1:0] leds_r;

  // Decode the gate number into its one-hot LED pattern
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < N_GATES; i++) begin
      if (gate == OUT_WIDTH'(i + 1)) begin
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // LED output register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      leds_r <= '0;
    end else if (clr) begin
      leds_r <= '0;
    end else begin
      leds_r <= onehot_s;
    end
  end

  assign leds = leds_r;

endmodule

// File: rtl/gate_scan.sv
// Register-mapped gate selector with key lockouts and an optional scan engine.
// Define GATE_SCAN_AUTO_EN to build the scan FSM with its MASK/DWELL registers.
module gate_scan
  import gate_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 8'h20,
  parameter int                    N_GATES     = 10,
  parameter int                    OUT_WIDTH   = $clog2(N_GATES + 1),
  parameter int                    DWELL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  init,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [N_GATES-1:0]    keys,
  output logic [OUT_WIDTH-1:0]  out,
  output logic [N_GATES-1:0]    leds,
  output logic                  scan_active,
  output logic                  gate_strobe
);

  localparam int                    WIDE     = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_GATE = DATA_WIDTH'(N_GATES);

  if (N_GATES < 1 || N_GATES > WIDE || DWELL_WIDTH < 1 || DWELL_WIDTH > WIDE) begin : g_bad_cfg
    $error("gate_scan: N_GATES or DWELL_WIDTH out of range");
  end

  // Returns vec[gate-1], or 0 for gate numbers outside 1..N_GATES
  function automatic logic bit_at(input logic [N_GATES-1:0] vec, input int gate);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_GATES; i++) begin
      if (gate == i + 1) begin
        r = vec[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [N_GATES-1:0]    keys_meta_r, keys_sync_r;
  logic [ERR_BITS-1:0]   err_r, err_next_s, err_gate_s, err_scan_s, w1c_s;
  logic [OUT_WIDTH-1:0]  gate_r, gate_next_s, out_r, out_next_s;
  logic [DATA_WIDTH-1:0] data_out_r, rdata_s, off_s, ctrl_rd_s;
  logic [WIDE-1:0]       mask_rd_s, dwell_rd_s;
  logic                  strobe_r, busy_s, clear_s, mapped_s;
  logic                  wr_ctrl_s, wr_err_s, wr_gate_s;
  logic [2:0]            reg_s;

  assign off_s     = addr - BASE_ADDR;
  assign mapped_s  = off_s < DATA_WIDTH'(8);
  assign reg_s     = off_s[2:0];
  assign wr_ctrl_s = we & mapped_s & (reg_s == REG_CTRL);
  assign wr_err_s  = we & mapped_s & (reg_s == REG_ERR);
  assign wr_gate_s = we & mapped_s & (reg_s == REG_GATE);
  assign clear_s   = init | (wr_ctrl_s & data_in[CTRL_SRST]);
  assign w1c_s     = wr_err_s ? data_in[ERR_BITS-1:0] : '0;

  // Key synchroniser; resets to all-locked so nothing is granted before real key levels arrive
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      keys_meta_r <= '1;
      keys_sync_r <= '1;
    end else begin
      keys_meta_r <= keys;
      keys_sync_r <= keys_meta_r;
    end
  end

  // Manual GATE write: range and lockout checks, rejected while scanning
  always_comb begin
    gate_next_s = gate_r;
    err_gate_s  = '0;
    if (wr_gate_s) begin
      if (busy_s) begin
        err_gate_s[ERR_BUSY] = 1'b1;
      end else if (data_in > MAX_GATE) begin
        gate_next_s           = '0;
        err_gate_s[ERR_RANGE] = 1'b1;
      end else if (bit_at(keys_sync_r, int'(data_in))) begin
        gate_next_s            = '0;
        err_gate_s[ERR_LOCKED] = 1'b1;
      end else begin
        gate_next_s = OUT_WIDTH'(data_in);
      end
    end else begin
      gate_next_s = gate_r;
    end
  end

  assign err_next_s = (err_r & ~w1c_s) | err_gate_s | err_scan_s;

`ifdef GATE_SCAN_AUTO_EN
  localparam logic [WIDE-1:0]      ONES        = {WIDE{1'b1}};
  localparam logic [WIDE-1:0]      MASK_VALID  = ONES >> (WIDE - N_GATES);
  localparam logic [WIDE-1:0]      DWELL_VALID = ONES >> (WIDE - DWELL_WIDTH);
  localparam logic [OUT_WIDTH-1:0] LAST_GATE   = OUT_WIDTH'(N_GATES);

  scan_state_e            state_r, state_next_s;
  logic                   scan_en_r, scan_en_next_s, one_shot_r, active_r, scan_stop_s;
  logic [WIDE-1:0]        mask_r, dwell_r;
  logic [OUT_WIDTH-1:0]   cand_r, cand_next_s, tried_r, tried_next_s, out_scan_s;
  logic [DWELL_WIDTH-1:0] cnt_r, cnt_next_s, dwell_len_s;
  logic                   hit_s, exhaust_s, cand_last_s, out_last_s, leave_dwell_s;
  logic                   wr_mask_lo_s, wr_mask_hi_s, wr_dwell_lo_s, wr_dwell_hi_s;

  assign wr_mask_lo_s  = we & mapped_s & (reg_s == REG_MASK_LO);
  assign wr_mask_hi_s  = we & mapped_s & (reg_s == REG_MASK_HI);
  assign wr_dwell_lo_s = we & mapped_s & (reg_s == REG_DWELL_LO);
  assign wr_dwell_hi_s = we & mapped_s & (reg_s == REG_DWELL_HI);

  assign dwell_len_s   = (dwell_r[DWELL_WIDTH-1:0] == '0) ? DWELL_WIDTH'(1) : dwell_r[DWELL_WIDTH-1:0];
  assign hit_s         = bit_at(mask_r[N_GATES-1:0], int'(cand_r)) & ~bit_at(keys_sync_r, int'(cand_r));
  assign exhaust_s     = tried_r == OUT_WIDTH'(N_GATES - 1);
  assign cand_last_s   = cand_r == LAST_GATE;
  assign out_last_s    = out_r == LAST_GATE;
  assign leave_dwell_s = bit_at(keys_sync_r, int'(out_r)) | (cnt_r <= DWELL_WIDTH'(1));
  assign busy_s        = state_r != ST_IDLE;

  // Scan FSM state register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r <= ST_IDLE;
    end else if (clear_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scan FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (scan_en_r) state_next_s = ST_SEEK;
        else           state_next_s = ST_IDLE;
      end
      ST_SEEK: begin
        if (!scan_en_r)                                 state_next_s = ST_IDLE;
        else if (hit_s)                                 state_next_s = ST_DWELL;
        else if (exhaust_s || (cand_last_s && one_shot_r)) state_next_s = ST_IDLE;
        else                                            state_next_s = ST_SEEK;
      end
      ST_DWELL: begin
        if (!scan_en_r)                         state_next_s = ST_IDLE;
        else if (!leave_dwell_s)                state_next_s = ST_DWELL;
        else if (out_last_s && one_shot_r)      state_next_s = ST_IDLE;
        else                                    state_next_s = ST_SEEK;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Scan FSM outputs: candidate walk, dwell countdown, hardware stop and empty error
  always_comb begin
    cand_next_s  = cand_r;
    tried_next_s = tried_r;
    cnt_next_s   = cnt_r;
    out_scan_s   = out_r;
    scan_stop_s  = 1'b0;
    err_scan_s   = '0;
    case (state_r)
      ST_IDLE: begin
        cand_next_s  = OUT_WIDTH'(1);
        tried_next_s = '0;
      end
      ST_SEEK: begin
        if (!scan_en_r) begin
          cand_next_s = cand_r;
        end else if (hit_s) begin
          out_scan_s   = cand_r;
          cnt_next_s   = dwell_len_s;
          tried_next_s = '0;
        end else begin
          err_scan_s[ERR_EMPTY] = exhaust_s;
          scan_stop_s  = exhaust_s | (cand_last_s & one_shot_r);
          cand_next_s  = cand_last_s ? OUT_WIDTH'(1) : cand_r + OUT_WIDTH'(1);
          tried_next_s = tried_r + OUT_WIDTH'(1);
        end
      end
      ST_DWELL: begin
        if (!scan_en_r) begin
          cnt_next_s = cnt_r;
        end else if (leave_dwell_s) begin
          cand_next_s  = out_last_s ? OUT_WIDTH'(1) : out_r + OUT_WIDTH'(1);
          tried_next_s = '0;
          scan_stop_s  = out_last_s & one_shot_r;
        end else begin
          cnt_next_s = cnt_r - DWELL_WIDTH'(1);
        end
      end
      default: begin
        cand_next_s  = OUT_WIDTH'(1);
        tried_next_s = '0;
      end
    endcase
  end

  // A CTRL write in the same cycle as a hardware stop keeps the written scan_en
  assign scan_en_next_s = wr_ctrl_s ? data_in[CTRL_SCAN_EN] : (scan_stop_s ? 1'b0 : scan_en_r);
  assign out_next_s     = (state_next_s == ST_IDLE) ? gate_next_s : out_scan_s;

  // Scan configuration and datapath registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scan_en_r  <= 1'b0;
      one_shot_r <= 1'b0;
      active_r   <= 1'b0;
      mask_r     <= '0;
      dwell_r    <= '0;
      cand_r     <= '0;
      tried_r    <= '0;
      cnt_r      <= '0;
    end else if (clear_s) begin
      scan_en_r  <= 1'b0;
      one_shot_r <= 1'b0;
      active_r   <= 1'b0;
      mask_r     <= '0;
      dwell_r    <= '0;
      cand_r     <= '0;
      tried_r    <= '0;
      cnt_r      <= '0;
    end else begin
      scan_en_r  <= scan_en_next_s;
      one_shot_r <= wr_ctrl_s ? data_in[CTRL_ONE_SHOT] : one_shot_r;
      active_r   <= state_next_s != ST_IDLE;
      if (wr_mask_lo_s)      mask_r <= {mask_r[WIDE-1:DATA_WIDTH], data_in} & MASK_VALID;
      else if (wr_mask_hi_s) mask_r <= {data_in, mask_r[DATA_WIDTH-1:0]} & MASK_VALID;
      else                   mask_r <= mask_r;
      if (wr_dwell_lo_s)      dwell_r <= {dwell_r[WIDE-1:DATA_WIDTH], data_in} & DWELL_VALID;
      else if (wr_dwell_hi_s) dwell_r <= {data_in, dwell_r[DATA_WIDTH-1:0]} & DWELL_VALID;
      else                    dwell_r <= dwell_r;
      cand_r  <= cand_next_s;
      tried_r <= tried_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  assign ctrl_rd_s   = DATA_WIDTH'({one_shot_r, scan_en_r, 1'b0});
  assign mask_rd_s   = mask_r;
  assign dwell_rd_s  = dwell_r;
  assign scan_active = active_r;
`else
  assign busy_s      = 1'b0;
  assign err_scan_s  = '0;
  assign out_next_s  = gate_next_s;
  assign ctrl_rd_s   = '0;
  assign mask_rd_s   = '0;
  assign dwell_rd_s  = '0;
  assign scan_active = 1'b0;
`endif

  // Register read multiplexer
  always_comb begin
    rdata_s = '0;
    if (mapped_s) begin
      case (reg_s)
        REG_CTRL:     rdata_s = ctrl_rd_s;
        REG_ERR:      rdata_s = DATA_WIDTH'(err_r);
        REG_GATE:     rdata_s = DATA_WIDTH'(gate_r);
        REG_MASK_LO:  rdata_s = mask_rd_s[DATA_WIDTH-1:0];
        REG_MASK_HI:  rdata_s = mask_rd_s[WIDE-1:DATA_WIDTH];
        REG_DWELL_LO: rdata_s = dwell_rd_s[DATA_WIDTH-1:0];
        REG_DWELL_HI: rdata_s = dwell_rd_s[WIDE-1:DATA_WIDTH];
        REG_STATUS:   rdata_s = DATA_WIDTH'(out_r);
        default:      rdata_s = '0;
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  // Error, gate, output and read-data registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      err_r      <= '0;
      gate_r     <= '0;
      out_r      <= '0;
      strobe_r   <= 1'b0;
      data_out_r <= '0;
    end else if (clear_s) begin
      err_r      <= '0;
      gate_r     <= '0;
      out_r      <= '0;
      strobe_r   <= 1'b0;
      data_out_r <= '0;
    end else begin
      err_r      <= err_next_s;
      gate_r     <= gate_next_s;
      out_r      <= out_next_s;
      strobe_r   <= out_next_s != out_r;
      data_out_r <= rdata_s;
    end
  end

  gate_led_dec #(
    .N_GATES   (N_GATES),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_led_dec (
    .clk  (clk),
    .res  (res),
    .clr  (clear_s),
    .gate (out_r),
    .leds (leds)
  );

  assign out         = out_r;
  assign gate_strobe = strobe_r;
  assign data_out    = data_out_r;

endmodule
